// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I-subset control path:
// FSM states, opcodes and the datapath mux/ALU select codes.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_FAULT
  } state_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALUOP_IMM   = 3'b000;
  localparam logic [2:0] ALUOP_ADD   = 3'b100;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;

  localparam logic [1:0] ALUSRCA_PC    = 2'b00;
  localparam logic [1:0] ALUSRCA_OLDPC = 2'b01;
  localparam logic [1:0] ALUSRCA_RS1   = 2'b10;

  localparam logic [1:0] ALUSRCB_RS2  = 2'b00;
  localparam logic [1:0] ALUSRCB_IMM  = 2'b01;
  localparam logic [1:0] ALUSRCB_FOUR = 2'b10;

  localparam logic [1:0] RESULT_ALUOUT  = 2'b00;
  localparam logic [1:0] RESULT_MEMDATA = 2'b01;
  localparam logic [1:0] RESULT_ALURES  = 2'b10;
  localparam logic [1:0] RESULT_IMM     = 2'b11;

  // States that hold mem_req high and therefore run the wait timer.
  function automatic logic is_mem_state(input state_e s);
    return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle sequencer (master) and the datapath/memory (slave).
interface multicycle_ctrl_fsm_if #(
  parameter int unsigned CNT_W = 32
);
  logic [6:0]       op;
  logic             take_branch;
  logic             mem_ready;
  logic             mem_req;
  logic             memwrite;
  logic             adrsrc;
  logic             irwrite;
  logic             pcwrite;
  logic             regwrite;
  logic [1:0]       alusrca;
  logic [1:0]       alusrcb;
  logic [1:0]       resultsrc;
  logic [2:0]       aluop;
  logic             fault;
  logic             retire;
  logic [CNT_W-1:0] insn_count;

  modport master (
    input  op, take_branch, mem_ready,
    output mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
           alusrca, alusrcb, resultsrc, aluop, fault, retire, insn_count
  );

  modport slave (
    output op, take_branch, mem_ready,
    input  mem_req, memwrite, adrsrc, irwrite, pcwrite, regwrite,
           alusrca, alusrcb, resultsrc, aluop, fault, retire, insn_count
  );
endinterface

// File: rtl/mem_wait_timer.sv
// Counts consecutive mem_ready=0 cycles of one memory access; flags the wait that
// would reach MEM_TIMEOUT so the sequencer can divert to FAULT that same cycle.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear,
  input  logic inc,
  output logic expired
);
  localparam int unsigned W = $clog2(MEM_TIMEOUT + 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // count_q holds earlier waits only, so this is the MEM_TIMEOUT-th wait in a row.
  assign expired = inc && (count_q == W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Main sequencer for the multicycle RV32I-subset core: fetch/decode/execute/writeback
// with memory-ready stalls, wait timeout and illegal-opcode FAULT parking.
module multicycle_ctrl_fsm
  import riscv_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input logic                   clk,
  input logic                   reset_n,
  multicycle_ctrl_fsm_if.master bus
);
  state_e           state_q, state_d;
  logic [CNT_W-1:0] insn_count_q, insn_count_d;
  logic             in_mem, tmr_clear, tmr_inc, tmr_expired;

  logic             mem_req_o, memwrite_o, adrsrc_o, irwrite_o, pcwrite_o, regwrite_o;
  logic [1:0]       alusrca_o, alusrcb_o, resultsrc_o;
  logic [2:0]       aluop_o;
  logic             fault_o, retire_o;

  assign in_mem    = is_mem_state(state_q);
  assign tmr_inc   = in_mem && !bus.mem_ready;
  assign tmr_clear = !in_mem || bus.mem_ready;

  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (tmr_clear),
    .inc     (tmr_inc),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_FETCH: begin
        if (bus.mem_ready)    state_d = S_DECODE;
        else if (tmr_expired) state_d = S_FAULT;
      end
      S_DECODE: begin
        unique case (bus.op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXECR;
          OP_ITYPE:          state_d = S_EXECI;
          OP_BRANCH:         state_d = S_BRANCH;
          OP_JAL:            state_d = S_JAL;
          OP_LUI:            state_d = S_LUI;
          default:           state_d = S_FAULT;
        endcase
      end
      S_MEMADR:   state_d = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD: begin
        if (bus.mem_ready)    state_d = S_MEMWB;
        else if (tmr_expired) state_d = S_FAULT;
      end
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: begin
        if (bus.mem_ready)    state_d = S_FETCH;
        else if (tmr_expired) state_d = S_FAULT;
      end
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      S_LUI:      state_d = S_FETCH;
      S_FAULT:    state_d = S_FAULT;
      default:    state_d = S_FAULT;
    endcase
  end

  // Outputs are forced to their idle values while reset_n is low so nothing commits mid-access.
  always_comb begin
    mem_req_o   = 1'b0;
    memwrite_o  = 1'b0;
    adrsrc_o    = 1'b0;
    irwrite_o   = 1'b0;
    pcwrite_o   = 1'b0;
    regwrite_o  = 1'b0;
    alusrca_o   = ALUSRCA_PC;
    alusrcb_o   = ALUSRCB_FOUR;
    resultsrc_o = RESULT_ALUOUT;
    aluop_o     = ALUOP_ADD;
    fault_o     = 1'b0;
    retire_o    = 1'b0;
    if (reset_n) begin
      unique case (state_q)
        S_FETCH: begin
          mem_req_o   = 1'b1;
          resultsrc_o = RESULT_ALURES;
          irwrite_o   = bus.mem_ready;
          pcwrite_o   = bus.mem_ready;
        end
        S_DECODE: begin
          alusrca_o = ALUSRCA_OLDPC;
          alusrcb_o = ALUSRCB_IMM;
        end
        S_MEMADR: begin
          alusrca_o = ALUSRCA_RS1;
          alusrcb_o = ALUSRCB_IMM;
        end
        S_MEMREAD: begin
          mem_req_o = 1'b1;
          adrsrc_o  = 1'b1;
        end
        S_MEMWB: begin
          resultsrc_o = RESULT_MEMDATA;
          regwrite_o  = 1'b1;
          retire_o    = 1'b1;
        end
        S_MEMWRITE: begin
          mem_req_o  = 1'b1;
          memwrite_o = 1'b1;
          adrsrc_o   = 1'b1;
          retire_o   = bus.mem_ready;
        end
        S_EXECR: begin
          alusrca_o = ALUSRCA_RS1;
          alusrcb_o = ALUSRCB_RS2;
          aluop_o   = ALUOP_RTYPE;
        end
        S_EXECI: begin
          alusrca_o = ALUSRCA_RS1;
          alusrcb_o = ALUSRCB_IMM;
          aluop_o   = ALUOP_IMM;
        end
        S_ALUWB: begin
          regwrite_o = 1'b1;
          retire_o   = 1'b1;
        end
        S_BRANCH: begin
          pcwrite_o = bus.take_branch;
          retire_o  = 1'b1;
        end
        S_JAL: begin
          alusrca_o = ALUSRCA_OLDPC;
          pcwrite_o = 1'b1;
        end
        S_LUI: begin
          resultsrc_o = RESULT_IMM;
          regwrite_o  = 1'b1;
          retire_o    = 1'b1;
        end
        S_FAULT:  fault_o = 1'b1;
        default:  fault_o = 1'b1;
      endcase
    end
  end

  always_comb begin
    insn_count_d = insn_count_q + CNT_W'(retire_o);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      insn_count_q <= '0;
    end else begin
      insn_count_q <= insn_count_d;
    end
  end

  assign bus.mem_req    = mem_req_o;
  assign bus.memwrite   = memwrite_o;
  assign bus.adrsrc     = adrsrc_o;
  assign bus.irwrite    = irwrite_o;
  assign bus.pcwrite    = pcwrite_o;
  assign bus.regwrite   = regwrite_o;
  assign bus.alusrca    = alusrca_o;
  assign bus.alusrcb    = alusrcb_o;
  assign bus.resultsrc  = resultsrc_o;
  assign bus.aluop      = aluop_o;
  assign bus.fault      = fault_o;
  assign bus.retire     = retire_o;
  assign bus.insn_count = insn_count_q;

endmodule
